// File: rtl/dm_arbiter.sv
// Data-memory arbiter between the CPU MEM stage and an external loader/debug port.
// CPU has fixed priority; EXT is forced ahead after STARVE_MAX consecutive CPU wins in conflict.
module dm_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned AW         = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_cpu_req,
    input  logic          i_cpu_we,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [31:0]   i_cpu_wdata,
    input  logic [2:0]    i_cpu_type,
    output logic          o_cpu_stall,
    output logic [31:0]   o_cpu_rdata,
    output logic          o_cpu_valid,
    input  logic          i_ext_req,
    input  logic          i_ext_we,
    input  logic [AW-1:0] i_ext_addr,
    input  logic [31:0]   i_ext_wdata,
    input  logic [2:0]    i_ext_type,
    output logic          o_ext_gnt,
    output logic [31:0]   o_ext_rdata,
    output logic          o_ext_valid,
    output logic          o_mem_store,
    output logic          o_mem_load,
    output logic [AW-1:0] o_mem_addr,
    output logic [31:0]   o_mem_wdata,
    output logic [2:0]    o_mem_type,
    input  logic [31:0]   i_mem_rdata
);

    localparam int unsigned CW = $clog2(STARVE_MAX + 2);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACC = 2'd1,
        EXT_ACC = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_starve_cnt;
    logic            r_cpu_valid;
    logic            r_ext_valid;
    logic [31:0]     r_cpu_rdata;
    logic [31:0]     r_ext_rdata;
    logic            r_mem_store;
    logic            r_mem_load;
    logic [AW-1:0]   r_mem_addr;
    logic [31:0]     r_mem_wdata;
    logic [2:0]      r_mem_type;

    logic            w_idle;
    logic            w_starved;
    logic            w_ext_pick;
    logic            w_ext_win;
    logic            w_cpu_win;

    assign w_idle     = (r_state == IDLE);
    assign w_starved  = (r_starve_cnt == CW'(STARVE_MAX));
    assign w_ext_pick = i_ext_req && (!i_cpu_req || w_starved);
    assign w_ext_win  = w_idle && w_ext_pick;
    assign w_cpu_win  = w_idle && i_cpu_req && !w_ext_pick;

    // Grant is gated by reset so it reads low while the block is held in reset
    assign o_ext_gnt   = i_rst_n && w_ext_win;
    assign o_cpu_stall = i_cpu_req && !r_cpu_valid;

    assign o_cpu_valid = r_cpu_valid;
    assign o_ext_valid = r_ext_valid;
    assign o_cpu_rdata = r_cpu_rdata;
    assign o_ext_rdata = r_ext_rdata;
    assign o_mem_store = r_mem_store;
    assign o_mem_load  = r_mem_load;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_type  = r_mem_type;

    // Arbitration FSM with registered memory command and completion outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_cpu_valid  <= 1'b0;
            r_ext_valid  <= 1'b0;
            r_cpu_rdata  <= 32'h0000_0000;
            r_ext_rdata  <= 32'h0000_0000;
            r_mem_store  <= 1'b0;
            r_mem_load   <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 32'h0000_0000;
            r_mem_type   <= 3'd0;
        end else begin
            r_cpu_valid <= 1'b0;
            r_ext_valid <= 1'b0;
            r_mem_store <= 1'b0;
            r_mem_load  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_ext_win) begin
                        r_state      <= EXT_ACC;
                        r_starve_cnt <= '0;
                        r_mem_store  <= i_ext_we;
                        r_mem_load   <= !i_ext_we;
                        r_mem_addr   <= i_ext_addr;
                        r_mem_wdata  <= i_ext_wdata;
                        r_mem_type   <= i_ext_type;
                    end else if (w_cpu_win) begin
                        r_state     <= CPU_ACC;
                        r_mem_store <= i_cpu_we;
                        r_mem_load  <= !i_cpu_we;
                        r_mem_addr  <= i_cpu_addr;
                        r_mem_wdata <= i_cpu_wdata;
                        r_mem_type  <= i_cpu_type;
                        // Only a conflict the CPU wins counts toward EXT starvation
                        if (i_ext_req && !w_starved) begin
                            r_starve_cnt <= r_starve_cnt + CW'(1);
                        end else begin
                            r_starve_cnt <= r_starve_cnt;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                CPU_ACC: begin
                    r_state     <= IDLE;
                    r_cpu_valid <= 1'b1;
                    if (r_mem_load) begin
                        r_cpu_rdata <= i_mem_rdata;
                    end else begin
                        r_cpu_rdata <= r_cpu_rdata;
                    end
                end
                EXT_ACC: begin
                    r_state     <= IDLE;
                    r_ext_valid <= 1'b1;
                    if (r_mem_load) begin
                        r_ext_rdata <= i_mem_rdata;
                    end else begin
                        r_ext_rdata <= r_ext_rdata;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: stimulus pushes expected memory commands and
// completion data into queues, a negedge monitor pops and compares them.
module tb_dm_arbiter;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_req, cpu_we, ext_req, ext_we;
    logic [AW-1:0] cpu_addr, ext_addr;
    logic [31:0]   cpu_wdata, ext_wdata;
    logic [2:0]    cpu_type, ext_type;
    logic          cpu_stall, cpu_valid, ext_gnt, ext_valid;
    logic [31:0]   cpu_rdata, ext_rdata;
    logic          mem_store, mem_load;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic [2:0]    mem_type;

    always #5 clk = ~clk;

    dm_arbiter #(.STARVE_MAX(4), .AW(AW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
        .i_cpu_wdata(cpu_wdata), .i_cpu_type(cpu_type),
        .o_cpu_stall(cpu_stall), .o_cpu_rdata(cpu_rdata), .o_cpu_valid(cpu_valid),
        .i_ext_req(ext_req), .i_ext_we(ext_we), .i_ext_addr(ext_addr),
        .i_ext_wdata(ext_wdata), .i_ext_type(ext_type),
        .o_ext_gnt(ext_gnt), .o_ext_rdata(ext_rdata), .o_ext_valid(ext_valid),
        .o_mem_store(mem_store), .o_mem_load(mem_load), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_type(mem_type), .i_mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        case (a)
            32'h0000_0010: mem_model = 32'hDEAD_BEEF;
            32'h0000_0000: mem_model = 32'h1111_1111;
            32'h0000_0004: mem_model = 32'h2222_2222;
            32'h0000_0020: mem_model = 32'hCAFE_0020;
            default:       mem_model = a ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    assign mem_rdata = mem_model(mem_addr);

    typedef struct packed {
        logic        st;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [2:0]  ty;
    } mem_exp_t;

    mem_exp_t    mem_q[$];
    logic [31:0] cpu_q[$];
    logic [31:0] ext_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_mem(input logic st, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] ty);
        mem_exp_t e;
        e.st = st; e.addr = a; e.wd = wd; e.ty = ty;
        mem_q.push_back(e);
    endtask

    task automatic cpu_set(input logic rq, input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] ty);
        cpu_req = rq; cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_type = ty;
    endtask

    task automatic ext_set(input logic rq, input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] ty);
        ext_req = rq; ext_we = we; ext_addr = a; ext_wdata = wd; ext_type = ty;
    endtask

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    // Scoreboard monitor: every strobe or completion must match the head of its queue
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_store || mem_load) begin
                if (mem_q.size() == 0) begin
                    check("mem_unexpected_strobe", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    mem_exp_t e;
                    e = mem_q.pop_front();
                    check("mem_store", 32'(mem_store), 32'(e.st));
                    check("mem_load", 32'(mem_load), 32'(!e.st));
                    check("mem_addr", mem_addr, e.addr);
                    check("mem_type", 32'(mem_type), 32'(e.ty));
                    if (e.st) check("mem_wdata", mem_wdata, e.wd);
                end
            end
            if (cpu_valid) begin
                if (cpu_q.size() == 0) check("cpu_valid_unexpected", 32'(cpu_valid), 32'd0);
                else check("cpu_rdata", cpu_rdata, cpu_q.pop_front());
            end
            if (ext_valid) begin
                if (ext_q.size() == 0) check("ext_valid_unexpected", 32'(ext_valid), 32'd0);
                else check("ext_rdata", ext_rdata, ext_q.pop_front());
            end
        end
    end

    // Both requesters held high: CPU wins n conflicts, EXT once, then CPU again
    task automatic starve_run(input int n, input logic [31:0] ca, input logic [31:0] ea,
                              input logic [31:0] crd, input logic [31:0] erd);
        for (int j = 0; j < n; j++) begin
            push_mem(1'b0, ca, 32'h0, 3'd2);
            cpu_q.push_back(crd);
        end
        push_mem(1'b0, ea, 32'h0, 3'd2);
        ext_q.push_back(erd);
        push_mem(1'b0, ca, 32'h0, 3'd2);
        cpu_q.push_back(crd);
        cpu_set(1'b1, 1'b0, ca, 32'h0, 3'd2);
        ext_set(1'b1, 1'b0, ea, 32'h0, 3'd2);
        for (int i = 0; i <= 2 * n + 4; i++) begin
            #1;
            check("starve_gnt", 32'(ext_gnt), 32'(i == 2 * n));
            if (i == 2 * n + 1) ext_set(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
            if (i == 2 * n + 4) begin
                check("starve_final_cpu_valid", 32'(cpu_valid), 32'd1);
                cpu_set(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
            end else begin
                nxt();
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values, with both requests already high
        cpu_set(1'b1, 1'b0, 32'h10, 32'h0, 3'd2);
        ext_set(1'b1, 1'b1, 32'h44, 32'h1234_5678, 3'd1);
        #12;
        check("rst_mem_store", 32'(mem_store), 32'd0);
        check("rst_mem_load", 32'(mem_load), 32'd0);
        check("rst_ext_gnt", 32'(ext_gnt), 32'd0);
        check("rst_cpu_valid", 32'(cpu_valid), 32'd0);
        check("rst_ext_valid", 32'(ext_valid), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_type", 32'(mem_type), 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        check("rst_ext_rdata", ext_rdata, 32'h0);
        ext_set(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);

        // CPU load of 0x10; first arbitration on first edge after release
        push_mem(1'b0, 32'h10, 32'h0, 3'd2);
        cpu_q.push_back(32'hDEAD_BEEF);
        rst_n = 1'b1;
        #1;
        check("load_stall_c0", 32'(cpu_stall), 32'd1);
        nxt();
        check("load_strobe_c1", 32'(mem_load), 32'd1);
        check("load_stall_c1", 32'(cpu_stall), 32'd1);
        check("load_valid_c1", 32'(cpu_valid), 32'd0);
        nxt();
        check("load_valid_c2", 32'(cpu_valid), 32'd1);
        check("load_stall_c2", 32'(cpu_stall), 32'd0);
        check("load_strobe_c2", 32'(mem_load), 32'd0);
        cpu_set(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        nxt();
        check("load_valid_pulse", 32'(cpu_valid), 32'd0);
        check("load_rdata_hold", cpu_rdata, 32'hDEAD_BEEF);

        // Simultaneous stores: CPU first, EXT granted on the following IDLE cycle
        push_mem(1'b1, 32'h100, 32'hAAAA_0001, 3'd2);
        cpu_q.push_back(32'hDEAD_BEEF);
        push_mem(1'b1, 32'h200, 32'hBBBB_0002, 3'd1);
        ext_q.push_back(32'h0);
        cpu_set(1'b1, 1'b1, 32'h100, 32'hAAAA_0001, 3'd2);
        ext_set(1'b1, 1'b1, 32'h200, 32'hBBBB_0002, 3'd1);
        #1;
        check("both_gnt_c0", 32'(ext_gnt), 32'd0);
        nxt();
        check("both_gnt_c1", 32'(ext_gnt), 32'd0);
        nxt();
        check("both_cpu_valid", 32'(cpu_valid), 32'd1);
        cpu_set(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        #1;
        check("both_ext_gnt", 32'(ext_gnt), 32'd1);
        nxt();
        ext_set(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        nxt();
        check("both_ext_valid", 32'(ext_valid), 32'd1);
        nxt();

        // Starvation from a cleared counter
        starve_run(4, 32'h20, 32'h24, 32'hCAFE_0020, 32'h5A5A_5A7E);
        nxt();

        // EXT withdraws after losing one conflict; that CPU win stays counted
        push_mem(1'b1, 32'h300, 32'h3333_0003, 3'd0);
        cpu_q.push_back(32'hCAFE_0020);
        cpu_set(1'b1, 1'b1, 32'h300, 32'h3333_0003, 3'd0);
        ext_set(1'b1, 1'b0, 32'h304, 32'h0, 3'd2);
        #1;
        check("drop_gnt_c0", 32'(ext_gnt), 32'd0);
        nxt();
        ext_set(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        nxt();
        check("drop_cpu_valid", 32'(cpu_valid), 32'd1);
        cpu_set(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("drop_no_gnt", 32'(ext_gnt), 32'd0);
            nxt();
        end
        starve_run(3, 32'h20, 32'h28, 32'hCAFE_0020, 32'h5A5A_5A72);
        nxt();

        // Reset asserted during CPU_ACC aborts the access; request re-served afterwards
        push_mem(1'b0, 32'h10, 32'h0, 3'd2);
        push_mem(1'b0, 32'h10, 32'h0, 3'd2);
        cpu_q.push_back(32'hDEAD_BEEF);
        cpu_set(1'b1, 1'b0, 32'h10, 32'h0, 3'd2);
        nxt();
        check("abort_strobe", 32'(mem_load), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_mem_load", 32'(mem_load), 32'd0);
        check("abort_mem_addr", mem_addr, 32'h0);
        check("abort_cpu_rdata", cpu_rdata, 32'h0);
        check("abort_ext_rdata", ext_rdata, 32'h0);
        nxt();
        check("abort_no_valid", 32'(cpu_valid), 32'd0);
        rst_n = 1'b1;
        nxt();
        check("reserve_strobe", 32'(mem_load), 32'd1);
        nxt();
        check("reserve_valid", 32'(cpu_valid), 32'd1);

        // Back-to-back loads: next request presented in the valid cycle
        cpu_set(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        nxt();
        push_mem(1'b0, 32'h0, 32'h0, 3'd2);
        cpu_q.push_back(32'h1111_1111);
        push_mem(1'b0, 32'h4, 32'h0, 3'd2);
        cpu_q.push_back(32'h2222_2222);
        cpu_set(1'b1, 1'b0, 32'h0, 32'h0, 3'd2);
        nxt();
        nxt();
        check("b2b_valid_a", 32'(cpu_valid), 32'd1);
        cpu_set(1'b1, 1'b0, 32'h4, 32'h0, 3'd2);
        nxt();
        check("b2b_gap", 32'(cpu_valid), 32'd0);
        nxt();
        check("b2b_valid_b", 32'(cpu_valid), 32'd1);
        cpu_set(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        nxt();
        nxt();
        check("final_cpu_rdata", cpu_rdata, 32'h2222_2222);
        check("final_mem_q_empty", 32'(mem_q.size()), 32'd0);
        check("final_cpu_q_empty", 32'(cpu_q.size()), 32'd0);
        check("final_ext_q_empty", 32'(ext_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
